// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TARGET,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHECK,
    ST_RUN
  } state_t;

  localparam logic [7:0] TGT_IMEM = 8'h00;
  localparam logic [7:0] TGT_RF   = 8'h01;
  localparam logic [7:0] TGT_GO   = 8'hFF;

  localparam int unsigned RF_WORDS = 32;
  localparam int unsigned IMEM_BPW = 4;
  localparam int unsigned RF_BPW   = 8;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian word assembler: shifts accepted bytes in and flags the byte that completes a word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        wide,
  input  logic [7:0]  data,
  output logic        word_done,
  output logic [63:0] word
);

  logic [63:0] sh_q;
  logic [63:0] sh_next;
  logic [2:0]  cnt_q;
  logic        last;

  // word includes the byte being accepted now, so the caller can register it alongside the strobe
  always_comb begin
    sh_next   = {data, sh_q[63:8]};
    last      = wide ? (cnt_q == 3'(RF_BPW - 1)) : (cnt_q == 3'(IMEM_BPW - 1));
    word_done = en && last;
    word      = wide ? sh_next : {32'h0, sh_next[63:32]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (en) begin
      sh_q  <= sh_next;
      cnt_q <= last ? '0 : cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream boot loader: writes IMEM/RF images and releases the core on a valid go frame.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_AW = 8,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               rf_we,
  output logic [4:0]         rf_addr,
  output logic [63:0]        rf_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  state_t      state_q, state_d;
  logic [7:0]  tgt_q, tgt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] widx_q, widx_d;
  logic [7:0]  chk_q, chk_d;
  logic        err_q, err_d;

  logic        accept;
  logic [15:0] lenv;
  logic        len_bad;
  logic        asm_clr, asm_en, word_done;
  logic [63:0] asm_word;

  assign in_ready = (state_q != ST_RUN);
  assign cpu_hold = (state_q != ST_RUN);
  assign done     = (state_q == ST_RUN);
  assign error    = err_q;
  assign accept   = in_valid && in_ready;
  assign lenv     = {in_data, len_q[7:0]};

  always_comb begin
    len_bad = 1'b0;
    unique case (tgt_q)
      TGT_IMEM: len_bad = 32'(lenv) > (32'd1 << IMEM_AW);
      TGT_RF:   len_bad = lenv > 16'(RF_WORDS);
      default:  len_bad = lenv != 16'd0;
    endcase
  end

  byte_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .clr       (asm_clr),
    .en        (asm_en),
    .wide      (tgt_q == TGT_RF),
    .data      (in_data),
    .word_done (word_done),
    .word      (asm_word)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    len_d   = len_q;
    widx_d  = widx_q;
    chk_d   = chk_q;
    err_d   = err_q;
    asm_clr = 1'b0;
    asm_en  = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_data == SYNC) begin
            state_d = ST_TARGET;
            chk_d   = '0;
            widx_d  = '0;
            asm_clr = 1'b1;
          end
        end
        ST_TARGET: begin
          chk_d = chk_q ^ in_data;
          tgt_d = in_data;
          if (in_data == TGT_IMEM || in_data == TGT_RF || in_data == TGT_GO) begin
            state_d = ST_LEN0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_LEN0: begin
          chk_d       = chk_q ^ in_data;
          len_d[7:0]  = in_data;
          state_d     = ST_LEN1;
        end
        ST_LEN1: begin
          chk_d       = chk_q ^ in_data;
          len_d[15:8] = in_data;
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (lenv == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          chk_d  = chk_q ^ in_data;
          asm_en = 1'b1;
          if (word_done) begin
            widx_d = widx_q + 16'd1;
            if (widx_q + 16'd1 == len_q) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if ((chk_q ^ in_data) != 8'h00) err_d = 1'b1;
          else if (tgt_q == TGT_GO && !err_q) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      len_q   <= '0;
      widx_q  <= '0;
      chk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
    end
  end

  // Strobes and write data register off the completing byte, landing one cycle after it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
    end else begin
      imem_we <= word_done && (tgt_q == TGT_IMEM);
      rf_we   <= word_done && (tgt_q == TGT_RF);
      if (word_done && tgt_q == TGT_IMEM) begin
        imem_addr  <= widx_q[IMEM_AW-1:0];
        imem_wdata <= asm_word[31:0];
      end
      if (word_done && tgt_q == TGT_RF) begin
        rf_addr  <= widx_q[4:0];
        rf_wdata <= asm_word;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: frame table plus hand-written multi-cycle sequences.
module tb_program_loader;

  localparam int unsigned IMEM_AW = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         in_data = 8'h00;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               rf_we;
  logic [4:0]         rf_addr;
  logic [63:0]        rf_wdata;
  logic               cpu_hold;
  logic               done;
  logic               error;

  always #5 clock = ~clock;

  program_loader #(.IMEM_AW(IMEM_AW), .SYNC(8'hA5)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  bit         log_rf[$];
  int         log_addr[$];
  logic [63:0] log_data[$];

  always @(negedge clock) begin
    if (imem_we) begin
      log_rf.push_back(1'b0);
      log_addr.push_back(int'(imem_addr));
      log_data.push_back({32'h0, imem_wdata});
    end
    if (rf_we) begin
      log_rf.push_back(1'b1);
      log_addr.push_back(int'(rf_addr));
      log_data.push_back(rf_wdata);
    end
  end

  typedef struct {
    bit          rst;
    int          n;
    logic [255:0] b;
    int          exp_n;
    bit          last_rf;
    int          last_addr;
    logic [63:0] last_data;
    bit          exp_err;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    log_rf.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 8 && !ok; t++) begin
      ok = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_accept: byte %h not accepted within 8 cycles", d);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    clear_log();
  endtask

  function automatic logic [63:0] word_of(input int i);
    return 64'hF00D_5EED_0000_0000 ^ (64'(i) * 64'h0001_0203_0405_0607);
  endfunction

  task automatic send_frame(input logic [7:0] tgt, input logic [15:0] len, input bit thr);
    logic [7:0]  c;
    logic [63:0] w;
    int          bpw;
    bpw = (tgt == 8'h01) ? 8 : 4;
    c = tgt ^ len[7:0] ^ len[15:8];
    send_byte(8'hA5);
    send_byte(tgt);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int i = 0; i < int'(len); i++) begin
      w = word_of(i);
      for (int j = 0; j < bpw; j++) begin
        if (thr) idle($urandom_range(0, 3));
        send_byte(w[8*j +: 8]);
        c = c ^ w[8*j +: 8];
      end
    end
    send_byte(c);
    idle(3);
  endtask

  task automatic check_frame(input string name, input bit rf, input int len, input bit full);
    logic [63:0] e;
    check({name, "_nwrites"}, 64'(log_data.size()), 64'(len));
    for (int i = 0; i < log_data.size(); i++) begin
      if (full || i == log_data.size() - 1) begin
        e = rf ? word_of(i) : {32'h0, word_of(i)[31:0]};
        check($sformatf("%s_w%0d_kind", name, i), 64'(log_rf[i]), 64'(rf));
        check($sformatf("%s_w%0d_addr", name, i), 64'(log_addr[i]), 64'(i));
        check($sformatf("%s_w%0d_data", name, i), log_data[i], e);
      end
    end
    check({name, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic run_vec(input int i);
    int sz;
    if (vt[i].rst) do_reset();
    clear_log();
    for (int k = 0; k < vt[i].n; k++) send_byte(vt[i].b[8*(vt[i].n-1-k) +: 8]);
    idle(3);
    sz = log_data.size();
    check($sformatf("v%0d_nwrites", i), 64'(sz), 64'(vt[i].exp_n));
    if (vt[i].exp_n > 0 && sz > 0) begin
      check($sformatf("v%0d_kind", i), 64'(log_rf[sz-1]), 64'(vt[i].last_rf));
      check($sformatf("v%0d_addr", i), 64'(log_addr[sz-1]), 64'(vt[i].last_addr));
      check($sformatf("v%0d_data", i), log_data[sz-1], vt[i].last_data);
    end
    check($sformatf("v%0d_error", i), 64'(error), 64'(vt[i].exp_err));
    check($sformatf("v%0d_cpu_hold", i), 64'(cpu_hold), 64'd1);
    check($sformatf("v%0d_done", i), 64'(done), 64'd0);
    check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 12, 256'({8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h02, 8'h12, 8'h8B, 8'h98}),
               1, 1'b0, 0, 64'h8B12_0202, 1'b0};
    vt[1]  = '{1'b0, 13, 256'({8'hA5, 8'h01, 8'h01, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h14}),
               1, 1'b1, 0, 64'd20, 1'b0};
    vt[2]  = '{1'b0, 13, 256'({8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8A}),
               2, 1'b0, 1, 64'h8877_6655, 1'b0};
    vt[3]  = '{1'b0, 21, 256'({8'hA5, 8'h01, 8'h02, 8'h00, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                               8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB7}),
               2, 1'b1, 1, 64'h11, 1'b0};
    vt[4]  = '{1'b0, 5, 256'({8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}), 0, 1'b0, 0, 64'h0, 1'b0};
    vt[5]  = '{1'b1, 2, 256'({8'hA5, 8'h07}), 0, 1'b0, 0, 64'h0, 1'b1};
    vt[6]  = '{1'b1, 8, 256'({8'hA5, 8'h01, 8'h21, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00}), 0, 1'b0, 0, 64'h0, 1'b1};
    vt[7]  = '{1'b1, 6, 256'({8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00}), 0, 1'b0, 0, 64'h0, 1'b1};
    vt[8]  = '{1'b1, 8, 256'({8'hA5, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}), 0, 1'b0, 0, 64'h0, 1'b1};
    vt[9]  = '{1'b1, 9, 256'({8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h02, 8'h12, 8'h8B, 8'h99}),
               1, 1'b0, 0, 64'h8B12_0202, 1'b1};
    vt[10] = '{1'b0, 5, 256'({8'hA5, 8'hFF, 8'h00, 8'h00, 8'hFF}), 0, 1'b0, 0, 64'h0, 1'b1};

    // asynchronous reset, checked between clock edges
    @(posedge clock);
    #1 reset = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_rf_addr", 64'(rf_addr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    idle(2);
    reset = 1'b1;
    idle(1);

    for (int i = 0; i <= 4; i++) run_vec(i);

    send_byte(8'hA5);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    check("go_hold_before_chk", 64'(cpu_hold), 64'd1);
    send_byte(8'hFF);
    check("go_cpu_hold", 64'(cpu_hold), 64'd0);
    check("go_done", 64'(done), 64'd1);
    check("go_in_ready", 64'(in_ready), 64'd0);
    check("go_error", 64'(error), 64'd0);
    idle(4);
    check("run_stays", 64'(done), 64'd1);
    reset = 1'b0;
    #1;
    check("run_rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("run_rst_in_ready", 64'(in_ready), 64'd1);
    check("run_rst_done", 64'(done), 64'd0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // a partial word cut by reset must not leak into the next frame
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h02);
    do_reset();
    foreach (vt[0].b[k]) begin end
    for (int k = 3; k < 12; k++) send_byte(vt[0].b[8*(12-1-k) +: 8]);
    idle(3);
    check("partial_nwrites", 64'(log_data.size()), 64'd1);
    if (log_data.size() > 0) check("partial_data", log_data[0], 64'h8B12_0202);
    check("partial_error", 64'(error), 64'd0);

    for (int i = 5; i <= 10; i++) run_vec(i);

    do_reset();
    send_frame(8'h00, 16'd3, 1'b1);
    check_frame("thr_imem3", 1'b0, 3, 1'b1);

    do_reset();
    send_frame(8'h00, 16'd256, 1'b0);
    check_frame("imem256", 1'b0, 256, 1'b0);

    do_reset();
    send_frame(8'h01, 16'd32, 1'b0);
    check_frame("rf32", 1'b1, 32, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
